// File: rtl/fpu_bus_ctrl.sv
// Host-bus front end for the FPU core: packs narrow bus writes into operands,
// queues start commands in a FIFO and dispatches them to the datapath one at a time.
module fpu_bus_ctrl #(
  parameter int BUS_W = 8,
  parameter int DEPTH = 4,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BUS_W-1:0] databus_in,
  output logic [BUS_W-1:0] databus_out,
  input  logic [3:0]       addr,
  input  logic             cs,
  input  logic             rd,
  input  logic             wr,
  input  logic             end_ack,
  output logic             cmd_end,
  output logic             busy,
  output logic             core_start,
  output logic [OP_W-1:0]  core_op,
  output logic [31:0]      core_a,
  output logic [31:0]      core_b,
  input  logic             core_done,
  input  logic [31:0]      core_result
);

  localparam int NB        = 32 / BUS_W;
  localparam int PW        = $clog2(DEPTH);
  localparam int CW        = PW + 1;
  localparam int CMD_W     = OP_W + 64;
  localparam int SW        = CW + 4;
  localparam int A_BASE    = 0;
  localparam int B_BASE    = NB;
  localparam int OP_ADDR   = 2 * NB;
  localparam int CTRL_ADDR = 2 * NB + 1;
  localparam int RES_BASE  = 2 * NB + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Handshakes: a host write is taken once per falling edge of wr while cs is
  // low; the core sees core_start for one cycle with op/a/b and answers with a
  // one-cycle core_done; cmd_end then holds until a rising edge of end_ack.

  state_t            state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [31:0]       res_q;
  logic              wr_q;
  logic              ack_q;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [CMD_W-1:0]  cmd_q;
  logic [CMD_W-1:0]  mem_q [DEPTH];

  logic              wr_stb;
  logic              start_req;
  logic              clr_req;
  logic              full;
  logic              push;
  logic              pop;
  logic              capture;
  logic [SW-1:0]     status;

  assign wr_stb = !cs && !wr && wr_q;
  assign full   = (count_q == CW'(DEPTH));
  assign push   = start_req && !full;

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    start_req = 1'b0;
    clr_req   = 1'b0;
    if (wr_stb) begin
      for (int k = 0; k < NB; k++) begin
        if (addr == 4'(A_BASE + k)) a_d[k*BUS_W +: BUS_W] = databus_in;
        if (addr == 4'(B_BASE + k)) b_d[k*BUS_W +: BUS_W] = databus_in;
      end
      if (addr == 4'(OP_ADDR)) op_d = OP_W'(databus_in);
      if (addr == 4'(CTRL_ADDR)) begin
        start_req = databus_in[0];
        clr_req   = databus_in[1];
      end
    end
  end

  // A dropped start in the same write as a clear leaves overflow set.
  always_comb begin
    ovf_d = (ovf_q && !clr_req) || (start_req && full);
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core_done) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (end_ack && !ack_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      wr_q     <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cmd_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      wr_q    <= wr;
      ack_q   <= end_ack;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        cmd_q    <= mem_q[rd_ptr_q];
      end
      if (capture) res_q <= core_result;
    end
  end

  // The snapshot is taken from the live registers, so later rewrites of
  // A/B/OP never disturb commands already queued.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= {op_q, a_q, b_q};
  end

  assign core_start = (state_q == ISSUE);
  assign cmd_end    = (state_q == DONE);
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign {core_op, core_a, core_b} = cmd_q;
  assign status     = {count_q, ovf_q, full, cmd_end, busy};

  always_comb begin
    databus_out = '0;
    if (!cs && !rd) begin
      for (int k = 0; k < NB; k++) begin
        if (addr == 4'(A_BASE + k))   databus_out = a_q[k*BUS_W +: BUS_W];
        if (addr == 4'(B_BASE + k))   databus_out = b_q[k*BUS_W +: BUS_W];
        if (addr == 4'(RES_BASE + k)) databus_out = res_q[k*BUS_W +: BUS_W];
      end
      if (addr == 4'(OP_ADDR))   databus_out = BUS_W'(op_q);
      if (addr == 4'(CTRL_ADDR)) databus_out = BUS_W'(status);
    end
  end

endmodule

// File: tb/tb_fpu_bus_ctrl.sv
// Bench for fpu_bus_ctrl (8-bit bus, depth 4): directed steps with random data,
// checked against a command-queue model of the host-visible behaviour.
module tb_fpu_bus_ctrl;
  localparam int BUS_W = 8;
  localparam int DEPTH = 4;
  localparam int OP_W  = 4;
  localparam logic [3:0] A_AD    = 4'd0;
  localparam logic [3:0] B_AD    = 4'd4;
  localparam logic [3:0] OP_AD   = 4'd8;
  localparam logic [3:0] CTRL_AD = 4'd9;
  localparam logic [3:0] RES_AD  = 4'd10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [BUS_W-1:0] databus_in;
  logic [BUS_W-1:0] databus_out;
  logic [3:0]       addr;
  logic             cs, rd, wr, end_ack;
  logic             cmd_end, busy, core_start;
  logic [OP_W-1:0]  core_op;
  logic [31:0]      core_a, core_b;
  logic             core_done;
  logic [31:0]      core_result;

  always #5 clk = ~clk;

  fpu_bus_ctrl #(.BUS_W(BUS_W), .DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .databus_in(databus_in), .databus_out(databus_out),
    .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack), .cmd_end(cmd_end),
    .busy(busy), .core_start(core_start), .core_op(core_op), .core_a(core_a),
    .core_b(core_b), .core_done(core_done), .core_result(core_result)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model of host-visible state
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_op;
  bit          m_ovf, m_inflight, m_end, m_ack_lvl;
  logic [67:0] m_q[$];
  logic [67:0] m_disp[$];
  int          m_ndone;

  // core responder
  logic [67:0] disp_q[$];
  logic [31:0] res_tab[64];
  int          r_idx = 0;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_res = '0;
  int          core_lat = 3;
  bit          core_stall = 0;
  int          flush_req = 0;
  int          flush_seen = 0;
  logic        done_r, done_m;
  logic [31:0] res_r, res_m;

  assign core_done   = done_r | done_m;
  assign core_result = done_m ? res_m : res_r;

  initial begin : core_resp
    done_r = 1'b0;
    res_r  = '0;
    forever begin
      @(negedge clk);
      done_r = 1'b0;
      if (flush_seen != flush_req) begin
        pend       = 0;
        flush_seen = flush_req;
      end
      if (core_start === 1'b1) begin
        disp_q.push_back({core_op, core_a, core_b});
        pend     = 1;
        pend_cnt = core_lat;
        pend_res = res_tab[r_idx];
        r_idx++;
      end else if (pend && !core_stall) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          done_r = 1'b1;
          res_r  = pend_res;
          pend   = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_exp();
    int sz = m_q.size();
    int v  = sz * 16 + (m_ovf ? 8 : 0) + ((sz == DEPTH) ? 4 : 0) + (m_end ? 2 : 0)
             + ((m_inflight || sz > 0) ? 1 : 0);
    return 8'(v);
  endfunction

  task automatic model_dispatch();
    if (!m_inflight && m_q.size() > 0) begin
      m_inflight = 1;
      m_disp.push_back(m_q.pop_front());
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_op = '0; m_res = '0;
    m_ovf = 0; m_inflight = 0; m_end = 0;
    m_q.delete();
    m_ndone = m_disp.size();
  endtask

  task automatic model_write(input logic [3:0] ad, input logic [7:0] d);
    int sh;
    if (ad < 4) begin
      sh  = 8 * int'(ad);
      m_a = (m_a & ~(32'hff << sh)) | (32'(d) << sh);
    end else if (ad < 8) begin
      sh  = 8 * (int'(ad) - 4);
      m_b = (m_b & ~(32'hff << sh)) | (32'(d) << sh);
    end else if (ad == OP_AD) begin
      m_op = d[3:0];
    end else if (ad == CTRL_AD) begin
      if (d[1]) m_ovf = 0;
      if (d[0]) begin
        if (m_q.size() == DEPTH) m_ovf = 1;
        else m_q.push_back({m_op, m_a, m_b});
      end
      model_dispatch();
    end
  endtask

  task automatic bus_write(input logic [3:0] ad, input logic [7:0] d);
    @(negedge clk);
    addr = ad; databus_in = d; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    wr = 1'b1; cs = 1'b1;
    model_write(ad, d);
  endtask

  task automatic chk_read(input string tag, input logic [3:0] ad, input logic [7:0] exp);
    logic [7:0] d;
    @(negedge clk);
    addr = ad; cs = 1'b0; rd = 1'b0;
    #1;
    d = databus_out;
    cs = 1'b1; rd = 1'b1;
    chk(tag, 72'(d), 72'(exp));
  endtask

  task automatic chk_res(input string tag);
    for (int k = 0; k < 4; k++)
      chk_read(tag, RES_AD + 4'(k), 8'(m_res >> (8 * k)));
  endtask

  task automatic set_ack(input logic v);
    @(negedge clk);
    end_ack = v;
    if (v && !m_ack_lvl && m_end) begin
      m_end      = 0;
      m_inflight = 0;
      model_dispatch();
    end
    m_ack_lvl = v;
  endtask

  task automatic wait_end(input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (cmd_end === 1'b1) seen = 1;
    end
    chk({tag, "_cmd_end_rise"}, 72'(seen), 72'(1));
    m_end = 1;
    m_res = res_tab[m_ndone];
    m_ndone++;
    chk({tag, "_disp_cnt"}, 72'(disp_q.size()), 72'(m_disp.size()));
    if (disp_q.size() >= m_ndone)
      chk({tag, "_disp_fields"}, 72'(disp_q[m_ndone-1]), 72'(m_disp[m_ndone-1]));
  endtask

  task automatic finish_one(input string tag);
    wait_end(tag);
    repeat (4) @(negedge clk);
    chk({tag, "_cmd_end_hold"}, 72'(cmd_end), 72'(m_end));
    chk({tag, "_no_early_issue"}, 72'(disp_q.size()), 72'(m_disp.size()));
    chk_res({tag, "_res"});
    set_ack(1'b1);
    set_ack(1'b0);
    chk({tag, "_cmd_end_drop"}, 72'(cmd_end), 72'(m_end));
  endtask

  initial begin : main
    logic [31:0] va, vb;
    logic [7:0]  v0;
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = '0; databus_in = '0;
    end_ack = 1'b0; done_m = 1'b0; res_m = '0; rst_n = 1'b0;
    m_ack_lvl = 0;
    m_disp.delete();
    res_tab[0] = 32'h447bc7be;
    for (int i = 1; i < 64; i++) res_tab[i] = $urandom;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset values
    chk("rst_cmd_end", 72'(cmd_end), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_core_start", 72'(core_start), 72'(0));
    chk("rst_core_fields", 72'({core_op, core_a, core_b}), 72'(0));
    chk("rst_databus_out", 72'(databus_out), 72'(0));
    chk_read("rst_ctrl", CTRL_AD, ctrl_exp());
    chk_read("rst_res0", RES_AD, 8'h00);

    // single command, 5-cycle core
    core_lat = 5;
    va = 32'h43a98fbe;
    vb = 32'h4426ffdf;
    for (int k = 0; k < 4; k++) bus_write(A_AD + 4'(k), va[8*k +: 8]);
    for (int k = 0; k < 4; k++) bus_write(B_AD + 4'(k), vb[8*k +: 8]);
    bus_write(OP_AD, 8'h01);
    bus_write(CTRL_AD, 8'h01);
    finish_one("t1");
    chk_read("t1_res10_lit", RES_AD, 8'hbe);
    chk_read("t1_res13_lit", RES_AD + 4'd3, 8'h44);
    chk_read("t1_ctrl_idle", CTRL_AD, ctrl_exp());
    chk("t1_busy", 72'(busy), 72'(0));

    // three back-to-back starts
    core_stall = 1;
    core_lat   = $urandom_range(1, 4);
    for (int k = 0; k < 4; k++) bus_write(A_AD + 4'(k), 8'($urandom));
    for (int k = 0; k < 4; k++) bus_write(B_AD + 4'(k), 8'($urandom));
    bus_write(OP_AD, 8'($urandom_range(0, 15)));
    for (int i = 0; i < 3; i++) begin
      bus_write(A_AD, 8'($urandom));
      bus_write(CTRL_AD, 8'h01);
    end
    repeat (3) @(negedge clk);
    chk_read("t2_ctrl_count2", CTRL_AD, ctrl_exp());
    core_stall = 0;
    finish_one("t2a");
    finish_one("t2b");
    finish_one("t2c");

    // overflow with a stalled core
    core_stall = 1;
    core_lat   = $urandom_range(1, 5);
    for (int i = 0; i < 6; i++) begin
      bus_write(B_AD + 4'($urandom_range(0, 3)), 8'($urandom));
      bus_write(CTRL_AD, 8'h01);
    end
    repeat (2) @(negedge clk);
    chk_read("t3_ctrl_ovf_full", CTRL_AD, ctrl_exp());
    bus_write(CTRL_AD, 8'h02);
    chk_read("t3_ctrl_ovf_clr", CTRL_AD, ctrl_exp());
    core_stall = 0;
    for (int i = 0; i < 5; i++) finish_one("t3");
    chk_read("t3_ctrl_drained", CTRL_AD, ctrl_exp());

    // end_ack held high across two results
    core_stall = 1;
    core_lat   = 2;
    for (int i = 0; i < 2; i++) begin
      bus_write(A_AD + 4'd1, 8'($urandom));
      bus_write(CTRL_AD, 8'h01);
    end
    core_stall = 0;
    wait_end("t4a");
    chk_res("t4a_res");
    set_ack(1'b1);
    wait_end("t4b");
    repeat (5) @(negedge clk);
    chk("t4_held_ack_no_clear", 72'(cmd_end), 72'(m_end));
    set_ack(1'b0);
    @(negedge clk);
    chk("t4_ack_low_still_end", 72'(cmd_end), 72'(m_end));
    set_ack(1'b1);
    @(negedge clk);
    chk("t4_reraise_clears", 72'(cmd_end), 72'(m_end));
    chk_res("t4b_res");
    set_ack(1'b0);

    // long wr pulse, unmapped access, spurious core_done
    v0 = 8'($urandom);
    @(negedge clk);
    addr = A_AD; databus_in = v0; cs = 1'b0; wr = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      databus_in = v0 ^ 8'(i);
    end
    @(negedge clk);
    wr = 1'b1; cs = 1'b1;
    model_write(A_AD, v0);
    chk_read("t5_single_write", A_AD, m_a[7:0]);
    bus_write(4'd15, 8'hff);
    chk_read("t5_unmapped14", 4'd14, 8'h00);
    chk_read("t5_unmapped15", 4'd15, 8'h00);
    for (int k = 0; k < 4; k++) chk_read("t5_a_lanes", A_AD + 4'(k), 8'(m_a >> (8 * k)));
    chk_read("t5_op", OP_AD, 8'(m_op));
    @(negedge clk);
    res_m = $urandom; done_m = 1'b1;
    @(negedge clk);
    done_m = 1'b0;
    repeat (2) @(negedge clk);
    chk_res("t5_res_unchanged");
    chk("t5_idle_cmd_end", 72'(cmd_end), 72'(0));

    // reset during WAIT with two queued
    core_stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus_write(A_AD, 8'($urandom));
      bus_write(CTRL_AD, 8'h01);
    end
    repeat (3) @(negedge clk);
    chk_read("t6_ctrl_pre", CTRL_AD, ctrl_exp());
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("t6_cmd_end", 72'(cmd_end), 72'(0));
    chk("t6_busy", 72'(busy), 72'(0));
    chk_read("t6_ctrl_post", CTRL_AD, ctrl_exp());
    flush_req++;
    repeat (2) @(negedge clk);
    core_stall = 0;
    @(negedge clk);
    res_m = $urandom; done_m = 1'b1;
    @(negedge clk);
    done_m = 1'b0;
    repeat (3) @(negedge clk);
    chk_res("t6_res_zero");
    chk("t6_busy_after", 72'(busy), 72'(0));
    chk("t6_cmd_end_after", 72'(cmd_end), 72'(0));
    chk("t6_disp_cnt", 72'(disp_q.size()), 72'(m_disp.size()));
    chk_read("t6_a_cleared", A_AD, m_a[7:0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
